// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef logic [1:0] state_t;
    localparam state_t StRun   = 2'd0;
    localparam state_t StHalt  = 2'd1;
    localparam state_t StFault = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Bundle of imem, decode handshake and control signals around ifetch_ctrl.
interface ifetch_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fault;
    logic        busy;

    modport master (
        output imem_addr,
        input  imem_inst,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output fault,
        output busy
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  fault,
        input  busy
    );

endinterface

// File: rtl/ifetch_buf.sv
// Small synchronous FIFO of fetch entries; flush empties it in one cycle.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned PtrW = $clog2(BUF_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  fetch_entry_t    wdata_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o,
    output fetch_entry_t    head_o
);

    fetch_entry_t    mem_q [BUF_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(BUF_DEPTH));
    assign empty_o = (count_q == '0);
    // Masked so the head reads zero whenever nothing is valid.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch PC sequencer with redirect, halt and fault handling.
// Optional: define IFETCH_BOUND_CHECK_EN to fault on fetch PCs beyond the imem.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    localparam logic [32:0] ImemBytes = 33'(IMEM_DEPTH) * 33'd4;
`ifdef IFETCH_BOUND_CHECK_EN
    localparam bit BoundCheckEn = 1'b1;
`else
    localparam bit BoundCheckEn = 1'b0;
`endif

    state_t       state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         fault_q, fault_d;
    logic         push, pop, flush, oob;
    logic         full, empty;
    logic [$clog2(BUF_DEPTH):0] count;
    fetch_entry_t head, wr_entry;

    assign oob      = BoundCheckEn && ({1'b0, fetch_pc_q} >= ImemBytes);
    assign pop      = !empty && bus.out_ready;
    assign wr_entry = '{pc: fetch_pc_q, inst: bus.imem_inst};

    // Redirect dominates; a same-cycle pop is still delivered before the flush.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush = 1'b1;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                fetch_pc_d = bus.redirect_pc;
                state_d    = StRun;
                fault_d    = 1'b0;
            end else begin
                state_d = StFault;
                fault_d = 1'b1;
            end
        end else begin
            case (state_q)
                StRun: begin
                    if (oob) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end else if (bus.halt_req) begin
                        state_d = StHalt;
                    end else if (!full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
                    end
                end
                StHalt: begin
                    if (!bus.halt_req) state_d = StRun;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
        end
    end

    ifetch_buf #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(flush),
        .wdata_i(wr_entry),
        .count_o(count),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );

    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.fault     = fault_q;
    assign bus.busy      = (state_q == StRun) && (count != '0);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a queue-based reference model checked every cycle.
module tb_ifetch_ctrl;

    localparam int unsigned BUF_DEPTH  = 2;
    localparam int unsigned IMEM_DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_if bus ();

    ifetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(IMEM_DEPTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] imem [IMEM_DEPTH];
    assign bus.imem_inst = imem[bus.imem_addr[9:2]];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: mode 0=run, 1=halt, 2=fault; entries are {pc, inst}.
    logic [31:0] m_pc;
    int          m_mode;
    logic        m_fault;
    logic [63:0] m_q [$];

    function automatic logic [31:0] row_word(input logic [31:0] pc);
        return {22'b0, pc[9:2], 2'b00} ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit delivered;
        if (rst) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_mode  = 0;
            m_fault = 1'b0;
        end else begin
            delivered = (m_q.size() != 0) && bus.out_ready;
            if (delivered) void'(m_q.pop_front());
            if (bus.redirect_valid) begin
                m_q.delete();
                if (bus.redirect_pc % 4 == 0) begin
                    m_pc    = bus.redirect_pc;
                    m_mode  = 0;
                    m_fault = 1'b0;
                end else begin
                    m_mode  = 2;
                    m_fault = 1'b1;
                end
            end else if (m_mode == 0) begin
`ifdef IFETCH_BOUND_CHECK_EN
                if (m_pc >= 4 * IMEM_DEPTH) begin
                    m_mode  = 2;
                    m_fault = 1'b1;
                end else
`endif
                if (bus.halt_req) m_mode = 1;
                else if (m_q.size() < BUF_DEPTH) begin
                    m_q.push_back({m_pc, row_word(m_pc)});
                    m_pc = m_pc + 4;
                end
            end else if (m_mode == 1 && !bus.halt_req) begin
                m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("cyc_pc", bus.out_pc, m_q[0][63:32]);
                check("cyc_inst", bus.out_inst, m_q[0][31:0]);
            end
            check("cyc_addr", bus.imem_addr, m_pc);
            check("cyc_fault", 32'(bus.fault), 32'(m_fault));
            check("cyc_busy", 32'(bus.busy), 32'(m_mode == 0 && m_q.size() != 0));
        end
    end

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = (i * 4) ^ 32'hA5A5_0000;
        rst                = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt_req       = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_inst", bus.out_inst, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_fault", 32'(bus.fault), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        rst = 1'b0;
        tick();
        check("lat_valid", 32'(bus.out_valid), 32'h1);
        check("seq_pc0", bus.out_pc, 32'h0);
        tick();
        check("seq_pc4", bus.out_pc, 32'h4);
        tick();
        check("seq_pc8", bus.out_pc, 32'h8);
        tick();
        check("seq_pc12", bus.out_pc, 32'hC);
        check("seq_inst12", bus.out_inst, 32'hA5A5_000C);

        // Backpressure from a fresh reset.
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        repeat (6) tick();
        check("bp_addr", bus.imem_addr, 32'h8);
        check("bp_head", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_pc4", bus.out_pc, 32'h4);
        tick();
        check("bp_pc8", bus.out_pc, 32'h8);

        // Buffer holds 0x8,0xC with 0x10 in flight.
        redirect(32'h40);
        check("rd_flush", 32'(bus.out_valid), 32'h0);
        check("rd_addr", bus.imem_addr, 32'h40);
        tick();
        check("rd_pc", bus.out_pc, 32'h40);
        check("rd_inst", bus.out_inst, 32'hA5A5_0040);

        redirect(32'h42);
        check("mis_fault", 32'(bus.fault), 32'h1);
        check("mis_valid", 32'(bus.out_valid), 32'h0);
        check("mis_addr", bus.imem_addr, 32'h44);
        repeat (3) tick();
        check("mis_hold", bus.imem_addr, 32'h44);
        check("mis_sticky", 32'(bus.fault), 32'h1);
        redirect(32'h80);
        check("rec_fault", 32'(bus.fault), 32'h0);
        tick();
        check("rec_pc", bus.out_pc, 32'h80);

        redirect(32'h20);
        bus.out_ready = 1'b0;
        tick();
        tick();
        bus.halt_req  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("hlt_drain", bus.out_pc, 32'h24);
        repeat (3) tick();
        check("hlt_empty", 32'(bus.out_valid), 32'h0);
        check("hlt_addr", bus.imem_addr, 32'h28);
        check("hlt_busy", 32'(bus.busy), 32'h0);
        bus.halt_req = 1'b0;
        tick();
        check("hlt_wait", 32'(bus.out_valid), 32'h0);
        tick();
        check("hlt_resume", bus.out_pc, 32'h28);

        redirect(32'h3F8);
        tick();
        check("bnd_pc0", bus.out_pc, 32'h3F8);
        tick();
        check("bnd_pc1", bus.out_pc, 32'h3FC);
        tick();
`ifdef IFETCH_BOUND_CHECK_EN
        check("bnd_fault", 32'(bus.fault), 32'h1);
        check("bnd_valid", 32'(bus.out_valid), 32'h0);
`else
        check("bnd_pc2", bus.out_pc, 32'h400);
        check("bnd_inst", bus.out_inst, 32'hA5A5_0000);
        redirect(32'hFFFF_FFFC);
        tick();
        check("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc1", bus.out_pc, 32'h0);
`endif

        // Reset mid-operation together with a redirect.
        bus.out_ready = 1'b0;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        rst                = 1'b1;
        tick();
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        check("mr_valid", 32'(bus.out_valid), 32'h0);
        check("mr_addr", bus.imem_addr, 32'h0);
        check("mr_fault", 32'(bus.fault), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check("mr_pc", bus.out_pc, 32'h0);
        tick();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
